// File: rtl/rename_pkg.sv
// Shared rename-stage definitions used by the free list and the RAT.
//   PHYS_TAG_W  : width of a physical register tag
//   TAG_NONE    : reserved tag meaning "no tag"
//   TAG_INVALID : reserved tag meaning "invalid"
//   NUM_ARCH    : architectural registers, mapped to tags 0..NUM_ARCH-1 at reset
//   NUM_CKPT    : branch checkpoint pages
//   PTR_W       : free-list pointer width (index bits plus one wrap bit)
package rename_pkg;

    localparam int PHYS_TAG_W = 8;
    localparam logic [PHYS_TAG_W-1:0] TAG_NONE    = 8'd254;
    localparam logic [PHYS_TAG_W-1:0] TAG_INVALID = 8'd255;
    localparam int NUM_ARCH   = 32;
    localparam int NUM_CKPT   = 8;
    localparam int PTR_W      = 9;

endpackage

// File: rtl/free_list_ckpt.sv
// Checkpoint register file for the free-list head pointer.
//   clk, reset     : clock, synchronous active-high reset (all pages to 0)
//   save_state     : write enable
//   save_page      : page written on save_state
//   save_ptr       : head value to store
//   restore_page   : page read combinationally
//   restore_ptr    : stored head of restore_page
module free_list_ckpt #(
    parameter int NUM_CKPT = 8,
    parameter int PTR_W    = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        save_state,
    input  logic [$clog2(NUM_CKPT)-1:0] save_page,
    input  logic [PTR_W-1:0]            save_ptr,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_page,
    output logic [PTR_W-1:0]            restore_ptr
);

    logic [PTR_W-1:0] ckpt_q [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_q[i] <= '0;
            end
        end else if (save_state) begin
            ckpt_q[save_page] <= save_ptr;
        end
    end

    assign restore_ptr = ckpt_q[restore_page];

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list for the rename stage. A circular FIFO of free
// tags with a checkpointed head pointer so a branch restore undoes every
// allocation made after the matching save.
//   clk, reset              : clock, synchronous active-high reset
//   alloc_req               : pop the head tag (ignored when empty)
//   release_valid/_phy_addr : push a returned tag (reserved tags ignored)
//   save_state/save_page    : store post-pop head into a checkpoint page
//   restore_state/_page     : reload head from a page (wins over pop and save)
//   free_phy_addr           : current head tag
//   free_valid, free_count  : list non-empty, number of free tags
//   overflow_err            : sticky, a push was dropped because list was full
module phys_free_list #(
    parameter int NUM_ARCH = rename_pkg::NUM_ARCH,
    parameter int NUM_TAGS = 254,
    parameter int DEPTH    = 256,
    parameter int NUM_CKPT = rename_pkg::NUM_CKPT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic                        release_valid,
    input  logic [7:0]                  release_phy_addr,
    input  logic                        save_state,
    input  logic [$clog2(NUM_CKPT)-1:0] save_page,
    input  logic                        restore_state,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_page,
    output logic [7:0]                  free_phy_addr,
    output logic                        free_valid,
    output logic [8:0]                  free_count,
    output logic                        overflow_err
);

    import rename_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NUM_INIT = NUM_TAGS - NUM_ARCH;

    logic [PHYS_TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic                  overflow_q, overflow_d;
    logic [PTR_W-1:0]      count;
    logic [PTR_W-1:0]      post_pop_head;
    logic [PTR_W-1:0]      restore_ptr;
    logic                  pop;
    logic                  push_req;
    logic                  push;
    logic                  full;

    assign count         = tail_q - head_q;
    assign pop           = alloc_req && (count != '0);
    assign post_pop_head = head_q + PTR_W'(pop);

    always_comb begin
        head_d = post_pop_head;
        if (restore_state) begin
            head_d = restore_ptr;
        end
    end

    // Fullness is judged against the head this cycle will leave behind, so a
    // same-cycle pop makes room and the tail can never overrun the head.
    assign full     = (tail_q - head_d) == PTR_W'(NUM_TAGS);
    assign push_req = release_valid && (release_phy_addr < TAG_NONE);
    assign push     = push_req && !full;

    always_comb begin
        tail_d     = tail_q + PTR_W'(push);
        overflow_d = overflow_q || (push_req && full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= PTR_W'(NUM_INIT);
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < NUM_INIT) ? PHYS_TAG_W'(NUM_ARCH + i) : '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[tail_q[IDX_W-1:0]] <= release_phy_addr;
            end
        end
    end

    free_list_ckpt #(
        .NUM_CKPT (NUM_CKPT),
        .PTR_W    (PTR_W)
    ) u_ckpt (
        .clk          (clk),
        .reset        (reset),
        .save_state   (save_state && !restore_state),
        .save_page    (save_page),
        .save_ptr     (post_pop_head),
        .restore_page (restore_page),
        .restore_ptr  (restore_ptr)
    );

    assign free_phy_addr = mem_q[head_q[IDX_W-1:0]];
    assign free_valid    = (count != '0);
    assign free_count    = count;
    assign overflow_err  = overflow_q;

endmodule
